// File: rtl/trivium_pkg.sv
// Constants and state encoding shared by the Trivium core and its keystream consumers.
package trivium_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        OUT  = 2'd2
    } ks_state_e;

    localparam int TRIV_KEY_W = 80;
    localparam int TRIV_IV_W  = 80;
    localparam int KS_WORD_W  = 32;

endpackage

// File: rtl/trivium_ks_xor_if.sv
// Keystream, host data and result channels of the keystream XOR block.
interface trivium_ks_xor_if
    import trivium_pkg::*;
#(
    parameter int W = KS_WORD_W
);

    logic         KSin;
    logic         KSvld;
    logic         KSack;
    logic [W-1:0] Din;
    logic         Dlast;
    logic         Drdy;
    logic         Dack;
    logic [W-1:0] Dout;
    logic         Olast;
    logic         Dvld;
    logic         Ordy;

    modport master (
        output KSin, KSvld, Din, Dlast, Drdy, Ordy,
        input  KSack, Dack, Dout, Olast, Dvld
    );

    modport slave (
        input  KSin, KSvld, Din, Dlast, Drdy, Ordy,
        output KSack, Dack, Dout, Olast, Dvld
    );

endinterface

// File: rtl/trivium_ks_sipo.sv
// Serial-in/parallel-out keystream packer: first bit in ends up as the word MSB.
module trivium_ks_sipo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         shift,
    input  logic         ks_bit,
    output logic [W-1:0] word,
    output logic         full
);

    localparam int CW = $clog2(W);

    logic [W-2:0] ksreg;
    logic [CW-1:0] cnt;

    // word is the value the register would hold after this shift, so the
    // parent can capture a complete word in the same cycle as the last bit
    assign word = {ksreg, ks_bit};
    assign full = shift && (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ksreg <= '0;
            cnt   <= '0;
        end else if (clr || load) begin
            cnt <= '0;
        end else if (shift) begin
            ksreg <= word[W-2:0];
            cnt   <= full ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/trivium_ks_xor.sv
// Packs W serial keystream bits and XORs them with one host word (encrypt == decrypt).
module trivium_ks_xor
    import trivium_pkg::*;
#(
    parameter int W = KS_WORD_W
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              CLR,
    output logic              BSY,
    trivium_ks_xor_if.slave   bus
);

    ks_state_e    state, state_d;
    logic         ks_ack, d_ack;
    logic         ks_xfer, d_xfer, o_xfer;
    logic         load, ks_full;
    logic [W-1:0] ks_word, dreg, dout;
    logic         last, olast, dvld;

    // Handshakes are withheld during a flush so no word or bit is silently dropped
    assign ks_ack  = RSTn && EN && !CLR && (state == FILL);
    assign d_ack   = RSTn && EN && !CLR &&
                     ((state == IDLE) || ((state == OUT) && bus.Ordy));
    assign ks_xfer = bus.KSvld && ks_ack;
    assign d_xfer  = bus.Drdy && d_ack;
    assign o_xfer  = dvld && bus.Ordy;

    assign bus.KSack = ks_ack;
    assign bus.Dack  = d_ack;
    assign bus.Dout  = dout;
    assign bus.Olast = olast;
    assign bus.Dvld  = dvld;
    assign BSY       = (state != IDLE);

    trivium_ks_sipo #(.W(W)) u_sipo (
        .clk    (CLK),
        .rst_n  (RSTn),
        .clr    (CLR),
        .load   (load),
        .shift  (ks_xfer),
        .ks_bit (bus.KSin),
        .word   (ks_word),
        .full   (ks_full)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else if (CLR) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (d_xfer) begin
                    load    = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (ks_full) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                // A new word may be taken in the drain cycle to avoid an idle bubble
                if (o_xfer) begin
                    state_d = IDLE;
                    if (d_xfer) begin
                        load    = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dreg  <= '0;
            last  <= 1'b0;
            dout  <= '0;
            olast <= 1'b0;
            dvld  <= 1'b0;
        end else if (CLR) begin
            olast <= 1'b0;
            dvld  <= 1'b0;
        end else begin
            if (load) begin
                dreg <= bus.Din;
                last <= bus.Dlast;
            end
            if (ks_full) begin
                dout  <= dreg ^ ks_word;
                olast <= last;
                dvld  <= 1'b1;
            end else if (o_xfer) begin
                dvld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trivium_ks_xor.sv
// Directed and randomized checks of trivium_ks_xor (W=8) against a queue-based scoreboard.
module tb_trivium_ks_xor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic bsy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0] dataQ[$];
    logic         lastQ[$];
    logic         ksQ[$];
    int outCount = 0;
    int ksCount = 0;
    int acceptCyc = 0;
    int lastOutCyc = 0;
    int prevOutCyc = 0;
    logic [W-1:0] lastDout = '0;
    logic [W-1:0] expWord, ksWord;
    logic expLast, outPend, randDone;

    trivium_ks_xor_if #(.W(W)) bus();

    trivium_ks_xor #(.W(W)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .EN   (en),
        .CLR  (clr),
        .BSY  (bsy),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    // Scoreboard: words and keystream bits are queued on acceptance; a result
    // consumes one word plus W bits, the first accepted bit weighting the MSB.
    always @(negedge clk) begin
        if (!rst_n) begin
            dataQ.delete(); lastQ.delete(); ksQ.delete();
        end else begin
            outPend = (dataQ.size() > 0) && (ksQ.size() >= W);
            if (!clr) begin
                checkOutput("dvld_model", 32'(bus.Dvld), 32'(outPend));
                checkOutput("ksack_model", 32'(bus.KSack), 32'(en && dataQ.size() > 0 && ksQ.size() < W));
                checkOutput("dack_model", 32'(bus.Dack), 32'(en && (dataQ.size() == 0 || (outPend && bus.Ordy))));
                checkOutput("bsy_model", 32'(bsy), 32'(dataQ.size() > 0));
            end
            if (bus.Dvld && bus.Ordy && !clr) begin
                if (outPend) begin
                    ksWord = '0;
                    for (int i = 0; i < W; i++)
                        if (ksQ.pop_front()) ksWord = ksWord + W'(1 << (W - 1 - i));
                    expWord = dataQ.pop_front() ^ ksWord;
                    expLast = lastQ.pop_front();
                    checkOutput("dout", 32'(bus.Dout), 32'(expWord));
                    checkOutput("olast", 32'(bus.Olast), 32'(expLast));
                end else begin
                    checkOutput("spurious_out", 32'(1), 32'(0));
                end
                lastDout = bus.Dout;
                prevOutCyc = lastOutCyc;
                lastOutCyc = cyc;
                outCount++;
            end
            if (bus.Drdy && bus.Dack) begin
                dataQ.push_back(bus.Din);
                lastQ.push_back(bus.Dlast);
                acceptCyc = cyc;
            end
            if (bus.KSvld && bus.KSack) begin
                ksQ.push_back(bus.KSin);
                ksCount++;
            end
            if (clr) begin
                dataQ.delete(); lastQ.delete(); ksQ.delete();
            end
        end
    end

    task automatic driveData(input logic [W-1:0] d, input logic l);
        int t;
        t = 0;
        bus.Din = d; bus.Dlast = l; bus.Drdy = 1'b1;
        @(negedge clk);
        while (!bus.Dack && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) checkOutput("timeout_dack", 32'(0), 32'(1));
        @(posedge clk); #1;
        bus.Drdy = 1'b0;
    endtask

    task automatic driveKs(input logic [W-1:0] bits, input int nbits, input int gapAt, input int gapLen);
        int t;
        for (int i = 0; i < nbits; i++) begin
            if (i == gapAt) begin
                bus.KSvld = 1'b0;
                repeat (gapLen) begin @(posedge clk); #1; end
            end
            bus.KSvld = 1'b1;
            bus.KSin  = bits[W-1-i];
            t = 0;
            @(negedge clk);
            while (!bus.KSack && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) checkOutput("timeout_ksack", 32'(0), 32'(1));
            @(posedge clk); #1;
        end
        bus.KSvld = 1'b0;
    endtask

    task automatic applyStimulus(input logic [W-1:0] d, input logic l, input logic [W-1:0] ks,
                                 input int gapAt, input int gapLen);
        fork
            driveData(d, l);
            driveKs(ks, W, gapAt, gapLen);
        join
    endtask

    task automatic waitOut(input int target);
        int t;
        t = 0;
        while (outCount < target && t < 300) begin @(posedge clk); t++; end
        if (t >= 300) checkOutput("timeout_out", 32'(outCount), 32'(target));
        #1;
    endtask

    task automatic waitDvld();
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.Dvld && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) checkOutput("timeout_dvld", 32'(0), 32'(1));
    endtask

    initial begin
        int base, t;
        bus.KSin = 1'b0; bus.KSvld = 1'b0; bus.Din = '0; bus.Dlast = 1'b0;
        bus.Drdy = 1'b0; bus.Ordy = 1'b1; randDone = 1'b0;

        // Reset values with EN high so the handshake gating is visible
        #1 rst_n = 1'b0; en = 1'b1;
        #12;
        checkOutput("rst_dvld", 32'(bus.Dvld), 32'(0));
        checkOutput("rst_bsy", 32'(bsy), 32'(0));
        checkOutput("rst_dout", 32'(bus.Dout), 32'(0));
        checkOutput("rst_dack", 32'(bus.Dack), 32'(0));
        checkOutput("rst_ksack", 32'(bus.KSack), 32'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_dack", 32'(bus.Dack), 32'(1));
        @(posedge clk); #1;

        // Basic word with continuous keystream: latency W+1, one-cycle Dvld
        base = outCount;
        applyStimulus(8'hA5, 1'b0, 8'hB2, 99, 0);
        waitOut(base + 1);
        checkOutput("s1_dout", 32'(lastDout), 32'h17);
        checkOutput("s1_latency", 32'(lastOutCyc - acceptCyc), 32'(W + 1));
        checkOutput("s1_dvld_pulse", 32'(bus.Dvld), 32'(0));

        // Stalled keystream and back-pressure
        bus.Ordy = 1'b0;
        base = outCount;
        applyStimulus(8'hA5, 1'b0, 8'hB2, 4, 3);
        waitDvld();
        repeat (5) begin
            @(negedge clk);
            checkOutput("s2_hold_dvld", 32'(bus.Dvld), 32'(1));
            checkOutput("s2_hold_dout", 32'(bus.Dout), 32'h17);
            checkOutput("s2_ksack_out", 32'(bus.KSack), 32'(0));
        end
        @(posedge clk); #1 bus.Ordy = 1'b1;
        waitOut(base + 1);

        // Back-to-back words with no idle bubble
        base = outCount;
        fork
            begin driveData(8'hFF, 1'b0); driveData(8'h00, 1'b1); end
            begin driveKs(8'h0F, W, 99, 0); driveKs(8'hF0, W, 99, 0); end
        join
        waitOut(base + 2);
        checkOutput("s3_dout2", 32'(lastDout), 32'hF0);
        checkOutput("s3_spacing", 32'(lastOutCyc - prevOutCyc), 32'(W + 1));

        // Asynchronous reset mid-FILL
        fork
            driveData(8'h3C, 1'b0);
            driveKs(8'hFF, 5, 99, 0);
        join
        #2 rst_n = 1'b0;
        #1;
        checkOutput("s4_rst_dout", 32'(bus.Dout), 32'(0));
        checkOutput("s4_rst_bsy", 32'(bsy), 32'(0));
        checkOutput("s4_rst_dvld", 32'(bus.Dvld), 32'(0));
        @(negedge clk); @(posedge clk); #1 rst_n = 1'b1;
        base = outCount;
        applyStimulus(8'h3C, 1'b1, 8'h5A, 99, 0);
        waitOut(base + 1);
        checkOutput("s4_after_rst", 32'(lastDout), 32'h66);

        // Asynchronous reset while a result waits for Ordy
        bus.Ordy = 1'b0;
        applyStimulus(8'h81, 1'b1, 8'h7E, 99, 0);
        waitDvld();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("s4b_rst_dvld", 32'(bus.Dvld), 32'(0));
        checkOutput("s4b_rst_dout", 32'(bus.Dout), 32'(0));
        @(negedge clk); @(posedge clk); #1 rst_n = 1'b1; bus.Ordy = 1'b1;

        // EN low for 4 cycles in the middle of a fill
        base = outCount;
        t = ksCount;
        fork
            driveData(8'h5A, 1'b1);
            driveKs(8'hC3, W, 99, 0);
            begin
                int w;
                w = 0;
                while (ksCount < t + 3 && w < 100) begin @(negedge clk); w++; end
                @(posedge clk); #1 en = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("s5_en_ksack", 32'(bus.KSack), 32'(0));
                    checkOutput("s5_en_bsy", 32'(bsy), 32'(1));
                end
                @(posedge clk); #1 en = 1'b1;
            end
        join
        waitOut(base + 1);
        checkOutput("s5_en_dout", 32'(lastDout), 32'h99);

        // CLR mid-fill discards the word
        fork
            driveData(8'hC3, 1'b0);
            driveKs(8'hAA, 4, 99, 0);
        join
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        checkOutput("s5_clr_bsy", 32'(bsy), 32'(0));
        @(negedge clk);
        checkOutput("s5_clr_dack", 32'(bus.Dack), 32'(1));
        base = outCount;
        repeat (10) @(posedge clk);
        #1 checkOutput("s5_clr_no_out", 32'(outCount), 32'(base));

        // Decrypt symmetry
        applyStimulus(8'h17, 1'b1, 8'hB2, 99, 0);
        waitOut(base + 1);
        checkOutput("s6_decrypt", 32'(lastDout), 32'hA5);

        // Randomized words, keystream gaps and output back-pressure
        base = outCount;
        fork
            begin
                for (int k = 0; k < 20; k++)
                    applyStimulus(W'($urandom), 1'($urandom), W'($urandom),
                                  $urandom_range(0, 11), $urandom_range(1, 3));
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk); #1 bus.Ordy = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.Ordy = 1'b1;
        waitOut(base + 20);
        checkOutput("rand_count", 32'(outCount - base), 32'(20));

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/trivium_ks_xor.md
Name: trivium_ks_xor

Overview:
- Downstream consumer of the Trivium keystream generator.
- Takes the generator's serial keystream (1 bit/cycle, valid/ready) and packs W keystream bits into a word.
- XORs that word with one plaintext/ciphertext word accepted from the host, then presents the result with a valid/ready handshake.
- Sits between the Trivium core and the host data bus. Encryption and decryption are identical operations.

Parameters:
- W, 32, data word width in bits; legal range 8..128, must be a multiple of 8.
- CW, $clog2(W), width of the keystream bit counter (derived, not overridable).

Ports:
- CLK  in  1  system clock, all state on rising edge
- RSTn  in  1  reset, asynchronous, active-low
- EN  in  1  block enable; 0 blocks new input handshakes
- CLR  in  1  synchronous flush to IDLE, priority over everything except RSTn
- KSin  in  1  keystream bit from the Trivium core
- KSvld  in  1  KSin valid
- KSack  out  1  ready for a keystream bit (combinational)
- Din  in  W  data word to be XORed
- Dlast  in  1  Din is the final word of a message
- Drdy  in  1  Din valid
- Dack  out  1  ready for a data word (combinational)
- Dout  out  W  Din XOR packed keystream
- Olast  out  1  Dout belongs to the final word
- Dvld  out  1  Dout valid
- Ordy  in  1  downstream ready for Dout
- BSY  out  1  a word is in flight (state != IDLE)

Behaviour:
- Reset (RSTn=0, async): state=IDLE, cnt=0, dreg=0, ksreg=0. Dout=0, Olast=0, Dvld=0, BSY=0; KSack=0 and Dack=0 while RSTn=0.
- Transfers:
  - Keystream transfer = KSvld & KSack.
  - Data transfer = Drdy & Dack.
  - Output transfer = Dvld & Ordy.
- States:
  - IDLE:
    - Dack = EN.
    - On data transfer: dreg<=Din, last<=Dlast, cnt<=0 -> FILL.
  - FILL:
    - KSack = EN.
    - On keystream transfer: ksreg<={ksreg[W-2:0],KSin}, cnt<=cnt+1.
    - When the transfer happens with cnt==W-1: registered Dout<=dreg ^ {ksreg[W-2:0],KSin}, Olast<=last, Dvld<=1 -> OUT.
    - Consequence: the first keystream bit received XORs Din[W-1] (MSB-first, matching the core's byte-reversed bit order).
    - Gaps in KSvld stall the fill with no loss.
  - OUT:
    - Dout, Olast, Dvld held stable until Ordy.
    - Dack = EN & Ordy.
    - On Ordy without data transfer: Dvld<=0 -> IDLE.
    - On Ordy with simultaneous data transfer: Dvld<=0, dreg<=Din, cnt<=0 -> FILL (back-to-back, no idle bubble).
    - The output handshake completes regardless of EN.
- Latency: a data word accepted in cycle t with KSvld continuously high gives Dvld=1 in cycle t+W+1.
- Throughput: one word per W+1 cycles with Ordy tied high.
- EN=0: KSack=0, Dack=0, state and counters frozen; a pending OUT still drains on Ordy.
- CLR=1 at a clock edge: state<=IDLE, Dvld<=0, cnt<=0, Olast<=0; the partial word is discarded. Dout keeps its last value but is invalid.
- KSack is never asserted outside FILL, so the core is back-pressured whenever no data word is loaded.
- cnt never wraps: it is reset on entry to FILL and FILL is left at W-1.
- Reset mid-FILL or mid-OUT: immediate return to the reset values above; the in-flight word is lost and no partial Dvld is issued.
- BSY=1 in FILL and OUT (registered, updated with state).

Decomposition:
- Shared package trivium_pkg: state encoding enum (IDLE=2'd0, FILL=2'd1, OUT=2'd2), constant TRIV_KEY_W=80, TRIV_IV_W=80, and default word width constant KS_WORD_W=32. The core and this block use the same constants.
- One natural sub-module: trivium_ks_sipo, the W-bit serial-in/parallel-out keystream shifter with bit counter and "full" flag. The parent holds the FSM, data register and output register.

Test Plan (W=8):
- Basic word: Din=8'hA5, Drdy pulse; KSin=1,0,1,1,0,0,1,0 on 8 consecutive cycles, Ordy=1 -> Dvld=1 one cycle after the 8th bit, Dout=8'h17; Dvld=1 for exactly one cycle; BSY high from the cycle after Din acceptance until the output transfer.
- Stalled keystream and back-pressure: same data, KSvld low for 3 cycles after bit 4, Ordy held low for 5 cycles -> Dout=8'h17 and Dvld held constant until Ordy=1; KSack=0 throughout OUT.
- Back-to-back words: Din=8'hFF (Dlast=0) then 8'h00 (Dlast=1) presented in the OUT cycle with Ordy=1; keystream 8'h0F then 8'hF0 -> outputs 8'hF0 (Olast=0) then 8'hF0 (Olast=1); no IDLE cycle between words.
- Reset mid-operation: assert RSTn=0 asynchronously after 5 keystream bits -> Dvld, BSY, Dout drop to 0 before the next clock edge; a new word after release produces a correct result with no residue from the old bits.
- EN and CLR: EN=0 during FILL for 4 cycles -> KSack=0, cnt frozen, result unchanged. CLR=1 mid-FILL -> IDLE next cycle, Dvld never asserts for the discarded word, Dack=1 the following cycle.
- Decrypt symmetry: feed Dout from scenario 1 (8'h17) with the same keystream -> Dout=8'hA5.
